// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into one-cycle short / long / double-click /
// auto-repeat pulses plus held and busy levels for the OSD/menu controller.
module btn_event_decoder #(
  parameter int BTN_ACTIVE_LOW    = 1,
  parameter int LONG_PRESS_CYCLES = 2500000,
  parameter int DCLICK_CYCLES     = 800000,
  parameter int REPEAT_CYCLES     = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_short_press,
  output logic o_long_press,
  output logic o_double_click,
  output logic o_repeat,
  output logic o_held,
  output logic o_busy
);

  localparam int MAXC_LD = (LONG_PRESS_CYCLES > DCLICK_CYCLES) ? LONG_PRESS_CYCLES : DCLICK_CYCLES;
  localparam int MAXC    = (MAXC_LD > REPEAT_CYCLES) ? MAXC_LD : REPEAT_CYCLES;
  localparam int CW      = $clog2(MAXC + 1);

  localparam logic [CW-1:0] C_LONG_M1 = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] C_DCLK_M1 = CW'(DCLICK_CYCLES - 1);
  localparam logic [CW-1:0] C_REP_M1  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [CW-1:0] C_ZERO    = CW'(0);
  localparam logic [CW-1:0] C_SAT     = {CW{1'b1}};
  localparam logic          C_INV     = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic          C_DCLK_EN = (DCLICK_CYCLES != 0) ? 1'b1 : 1'b0;
  localparam logic          C_REP_EN  = (REPEAT_CYCLES != 0) ? 1'b1 : 1'b0;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESS1   = 3'd1;
  localparam logic [2:0] S_WAIT2    = 3'd2;
  localparam logic [2:0] S_WAIT_REL = 3'd3;
  localparam logic [2:0] S_LONG     = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_ctr;
  logic          r_act_prev;
  logic          r_short;
  logic          r_long;
  logic          r_dclick;
  logic          r_repeat;
  logic          r_held;
  logic          r_busy;

  logic          w_act;
  logic [2:0]    w_state_nxt;
  logic          w_ctr_clr;
  logic          w_short;
  logic          w_long;
  logic          w_dclick;
  logic          w_repeat;

  assign w_act = i_btn ^ C_INV;

  // Next-state and event decode; ctr is cleared on every state entry and on each repeat.
  always_comb begin
    w_state_nxt = r_state;
    w_ctr_clr   = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_dclick    = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_act && !r_act_prev) begin
          w_state_nxt = S_PRESS1;
          w_ctr_clr   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRESS1: begin
        if (!w_act) begin
          w_ctr_clr = 1'b1;
          if (C_DCLK_EN) begin
            w_state_nxt = S_WAIT2;
          end else begin
            w_short     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (r_ctr == C_LONG_M1) begin
          w_long      = 1'b1;
          w_state_nxt = S_LONG;
          w_ctr_clr   = 1'b1;
        end else begin
          w_state_nxt = S_PRESS1;
        end
      end
      S_WAIT2: begin
        if (w_act) begin
          w_dclick    = 1'b1;
          w_state_nxt = S_WAIT_REL;
          w_ctr_clr   = 1'b1;
        end else if (r_ctr == C_DCLK_M1) begin
          w_short     = 1'b1;
          w_state_nxt = S_IDLE;
          w_ctr_clr   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT2;
        end
      end
      S_WAIT_REL: begin
        if (!w_act) begin
          w_state_nxt = S_IDLE;
          w_ctr_clr   = 1'b1;
        end else begin
          w_state_nxt = S_WAIT_REL;
        end
      end
      S_LONG: begin
        if (!w_act) begin
          w_state_nxt = S_IDLE;
          w_ctr_clr   = 1'b1;
        end else if (C_REP_EN && (r_ctr == C_REP_M1)) begin
          w_repeat  = 1'b1;
          w_ctr_clr = 1'b1;
        end else begin
          w_state_nxt = S_LONG;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ctr_clr   = 1'b1;
      end
    endcase
  end

  // State, counter and edge-history registers; act_prev resets to pressed so a held button is ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_ctr      <= C_ZERO;
      r_act_prev <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_act_prev <= w_act;
      if (w_ctr_clr) begin
        r_ctr <= C_ZERO;
      end else if (r_ctr != C_SAT) begin
        r_ctr <= r_ctr + C_ONE;
      end else begin
        r_ctr <= r_ctr;
      end
    end
  end

  // Registered event pulses and status levels.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_dclick <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_short  <= w_short;
      r_long   <= w_long;
      r_dclick <= w_dclick;
      r_repeat <= w_repeat;
      r_held   <= (w_state_nxt == S_LONG);
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_short_press  = r_short;
  assign o_long_press   = r_long;
  assign o_double_click = r_dclick;
  assign o_repeat       = r_repeat;
  assign o_held         = r_held;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed, table-driven bench for btn_event_decoder (LONG=8, DCLICK=4, REPEAT=3)
// plus a DCLICK=0 instance for the immediate-short build.
module tb_btn_event_decoder;

  localparam logic [5:0] E0 = 6'b000000;
  localparam logic [5:0] SH = 6'b100000;
  localparam logic [5:0] LP = 6'b010000;
  localparam logic [5:0] DC = 6'b001000;
  localparam logic [5:0] RP = 6'b000100;
  localparam logic [5:0] HD = 6'b000010;
  localparam logic [5:0] BZ = 6'b000001;

  typedef struct {
    logic       btn;
    logic [5:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a = 1'b1;
  logic btn_b = 1'b1;
  logic a_short, a_long, a_dclick, a_rep, a_held, a_busy;
  logic b_short, b_long, b_dclick, b_rep, b_held, b_busy;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  btn_event_decoder #(
    .BTN_ACTIVE_LOW(1), .LONG_PRESS_CYCLES(8), .DCLICK_CYCLES(4), .REPEAT_CYCLES(3)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_a),
    .o_short_press(a_short), .o_long_press(a_long), .o_double_click(a_dclick),
    .o_repeat(a_rep), .o_held(a_held), .o_busy(a_busy)
  );

  btn_event_decoder #(
    .BTN_ACTIVE_LOW(1), .LONG_PRESS_CYCLES(8), .DCLICK_CYCLES(0), .REPEAT_CYCLES(3)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_btn(btn_b),
    .o_short_press(b_short), .o_long_press(b_long), .o_double_click(b_dclick),
    .o_repeat(b_rep), .o_held(b_held), .o_busy(b_busy)
  );

  wire [5:0] outs_a = {a_short, a_long, a_dclick, a_rep, a_held, a_busy};
  wire [5:0] outs_b = {b_short, b_long, b_dclick, b_rep, b_held, b_busy};

  task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {short,long,dclick,rep,held,busy}=%b, want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge: drive both buttons, then sample both DUTs just after the edge.
  task automatic step(input logic ba, input logic [5:0] ea, input logic bb, input logic [5:0] eb,
                      input string nm);
    @(negedge clk);
    btn_a = ba;
    btn_b = bb;
    @(posedge clk);
    #1;
    check({nm, "/a"}, outs_a, ea);
    check({nm, "/b"}, outs_b, eb);
  endtask

  task automatic add(input logic b, input int n, input logic [5:0] e, input string nm);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.btn  = b;
      v.exp  = e;
      v.name = nm;
      vecs.push_back(v);
    end
  endtask

  initial begin
    // case 1: short press resolved when the double-click window expires
    add(1'b0, 3, BZ, "c1_press");
    add(1'b1, 4, BZ, "c1_window");
    add(1'b1, 1, SH, "c1_short");
    add(1'b1, 2, E0, "c1_idle");
    // case 2: double click, then a 20-edge hold that must not become long
    add(1'b0, 3, BZ, "c2_press");
    add(1'b1, 2, BZ, "c2_gap");
    add(1'b0, 1, DC | BZ, "c2_dclick");
    add(1'b0, 19, BZ, "c2_hold");
    add(1'b1, 2, E0, "c2_release");
    // case 3: long press with two repeats
    add(1'b0, 8, BZ, "c3_press");
    add(1'b0, 1, LP | HD | BZ, "c3_long");
    add(1'b0, 2, HD | BZ, "c3_held1");
    add(1'b0, 1, RP | HD | BZ, "c3_rep1");
    add(1'b0, 2, HD | BZ, "c3_held2");
    add(1'b0, 1, RP | HD | BZ, "c3_rep2");
    add(1'b0, 1, HD | BZ, "c3_held3");
    add(1'b1, 2, E0, "c3_release");
    // case 4: release on the long-threshold edge is a short press
    add(1'b0, 8, BZ, "c4_press");
    add(1'b1, 4, BZ, "c4_window");
    add(1'b1, 1, SH, "c4_short");
    add(1'b1, 2, E0, "c4_idle");

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset/a", outs_a, E0);
    check("reset/b", outs_b, E0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, E0, 1'b1, E0, "post_reset_idle");
    step(1'b1, E0, 1'b1, E0, "post_reset_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].btn, vecs[i].exp, 1'b1, E0, vecs[i].name);
    end

    // case 5a: button held through reset deassertion is ignored until released
    @(negedge clk);
    btn_a = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) step(1'b0, E0, 1'b1, E0, "c5_held_thru_reset");
    step(1'b1, E0, 1'b1, E0, "c5_release");
    for (int i = 0; i < 3; i++) step(1'b0, BZ, 1'b1, E0, "c5_press");
    for (int i = 0; i < 4; i++) step(1'b1, BZ, 1'b1, E0, "c5_window");
    step(1'b1, SH, 1'b1, E0, "c5_short");
    step(1'b1, E0, 1'b1, E0, "c5_idle");

    // case 5b: reset pulse during a long hold drops outputs at once, nothing follows
    for (int i = 0; i < 5; i++) step(1'b0, BZ, 1'b1, E0, "c5_hold");
    #2;
    rst = 1'b1;
    #1;
    check("c5_async_reset/a", outs_a, E0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b0, E0, 1'b1, E0, "c5_after_reset");
    for (int i = 0; i < 6; i++) step(1'b1, E0, 1'b1, E0, "c5_release_idle");

    // case 6: DCLICK=0 build emits short on the release edge; second press is a new short
    for (int i = 0; i < 3; i++) step(1'b1, E0, 1'b0, BZ, "c6_press1");
    step(1'b1, E0, 1'b1, SH, "c6_short1");
    step(1'b1, E0, 1'b1, E0, "c6_idle1");
    for (int i = 0; i < 2; i++) step(1'b1, E0, 1'b0, BZ, "c6_press2");
    step(1'b1, E0, 1'b1, SH, "c6_short2");
    step(1'b1, E0, 1'b1, E0, "c6_idle2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
